level_controller: RTL

LEVEL_CONTROLLER -- requirements
Module: level_controller

---
 rtl/whack_pkg.sv | 51 +++++
 rtl/one_second_ticker.sv | 43 ++++
 rtl/level_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// ============================================================================
// Module : whack_pkg
// Brief  : Shared game constants: FSM encoding, level thresholds, mole speeds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [1:0]  C_LEVEL_MAX   = 2'd3;

    localparam logic [7:0]  C_LVL1_THRESH = 8'd10;
    localparam logic [7:0]  C_LVL2_THRESH = 8'd25;
    localparam logic [7:0]  C_LVL3_THRESH = 8'd50;

    localparam logic [27:0] C_SPEED_L0    = 28'd50_000_000;
    localparam logic [27:0] C_SPEED_L1    = 28'd37_500_000;
    localparam logic [27:0] C_SPEED_L2    = 28'd25_000_000;
    localparam logic [27:0] C_SPEED_L3    = 28'd12_500_000;

    // Score needed to leave the given level for the next one.
    function automatic logic [7:0] threshold_for_level(input logic [1:0] lvl);
        logic [7:0] thr;
        case (lvl)
            2'd0:    thr = C_LVL1_THRESH;
            2'd1:    thr = C_LVL2_THRESH;
            default: thr = C_LVL3_THRESH;
        endcase
        return thr;
    endfunction

    function automatic logic [27:0] speed_for_level(input logic [1:0] lvl);
        logic [27:0] spd;
        case (lvl)
            2'd0:    spd = C_SPEED_L0;
            2'd1:    spd = C_SPEED_L1;
            2'd2:    spd = C_SPEED_L2;
            default: spd = C_SPEED_L3;
        endcase
        return spd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/one_second_ticker.sv
// ============================================================================
// Module : one_second_ticker
// Brief  : Seconds prescaler; one-cycle tick every CLK_HZ enabled cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module one_second_ticker #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int            CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] C_RELOAD = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // While disabled the counter sits at reload so every round starts a full second.
    always_comb begin
        count_d = C_RELOAD;
        if (enable) begin
            count_d = (count_q == '0) ? C_RELOAD : count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= C_RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/level_controller.sv
// ============================================================================
// Module : level_controller
// Brief  : Round timer, difficulty level, mole speed and score bookkeeping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module level_controller
    import whack_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int GAME_SECONDS = 60
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  score,
    output logic        game,
    output logic [27:0] speed,
    output logic [1:0]  level,
    output logic [7:0]  time_left,
    output logic [7:0]  final_score,
    output logic [7:0]  best_score
);

    localparam logic [7:0] C_GAME_TIME = 8'(GAME_SECONDS);

    state_e      state_q,       state_d;
    logic        game_q,        game_d;
    logic [27:0] speed_q,       speed_d;
    logic [1:0]  level_q,       level_d;
    logic [7:0]  time_left_q,   time_left_d;
    logic [7:0]  final_score_q, final_score_d;
    logic [7:0]  best_score_q,  best_score_d;
    logic        start_prev_q,  start_prev_d;
    logic        start_edge_q,  start_edge_d;
    logic        w_tick;

    one_second_ticker #(
        .CLK_HZ (CLK_HZ)
    ) u_ticker (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state_q == ST_PLAY),
        .tick    (w_tick)
    );

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        time_left_d   = time_left_q;
        final_score_d = final_score_q;
        best_score_d  = best_score_q;
        start_prev_d  = start;
        start_edge_d  = start && !start_prev_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge_q) begin
                    state_d     = ST_PLAY;
                    level_d     = 2'd0;
                    time_left_d = C_GAME_TIME;
                end
            end
            ST_PLAY: begin
                if ((level_q != C_LEVEL_MAX) && (score >= threshold_for_level(level_q))) begin
                    level_d = level_q + 2'd1;
                end
                if (w_tick) begin
                    if (time_left_q == 8'd1) begin
                        state_d       = ST_OVER;
                        time_left_d   = 8'd0;
                        final_score_d = score;
                        if (score > best_score_q) begin
                            best_score_d = score;
                        end
                    end else begin
                        time_left_d = time_left_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        game_d  = (state_d == ST_PLAY);
        // Round entry and exit both force the base speed; otherwise follow last cycle's level.
        speed_d = ((state_q == ST_PLAY) && (state_d == ST_PLAY)) ? speed_for_level(level_q)
                                                                 : C_SPEED_L0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            game_q        <= 1'b0;
            speed_q       <= C_SPEED_L0;
            level_q       <= 2'd0;
            time_left_q   <= C_GAME_TIME;
            final_score_q <= 8'd0;
            best_score_q  <= 8'd0;
            start_prev_q  <= 1'b1;
            start_edge_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            game_q        <= game_d;
            speed_q       <= speed_d;
            level_q       <= level_d;
            time_left_q   <= time_left_d;
            final_score_q <= final_score_d;
            best_score_q  <= best_score_d;
            start_prev_q  <= start_prev_d;
            start_edge_q  <= start_edge_d;
        end
    end

    assign game        = game_q;
    assign speed       = speed_q;
    assign level       = level_q;
    assign time_left   = time_left_q;
    assign final_score = final_score_q;
    assign best_score  = best_score_q;

endmodule

`default_nettype wire
